// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module      : ifu_fetch
// Description : Single-outstanding instruction fetch unit. It issues one
//               memory read per pc and hands the word to decode.
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_fetch #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    output logic              pc_wen,
    input  logic              redirect,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [DATA_W-1:0] imem_resp_data,
    input  logic              imem_resp_err,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_fault,
    output logic [CNT_W-1:0]  fetch_cnt
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_inst;
    logic [ADDR_W-1:0] r_inst_pc;
    logic              r_inst_fault;
    logic [CNT_W-1:0]  r_fetch_cnt;
    logic              w_req_fire;
    logic              w_capture;
    logic              w_handoff;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Valids are gated by rst because the state register only clears at the edge.
    always_comb begin
        w_state_nxt    = r_state;
        w_req_fire     = 1'b0;
        w_capture      = 1'b0;
        w_handoff      = 1'b0;
        imem_req_valid = 1'b0;
        inst_valid     = 1'b0;
        if (!rst) begin
            case (r_state)
                S_REQ: begin
                    imem_req_valid = !redirect;
                    w_req_fire     = !redirect && imem_req_ready;
                    if (w_req_fire) begin
                        w_state_nxt = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        w_capture   = !redirect;
                        w_state_nxt = redirect ? S_REQ : S_OUT;
                    end else if (redirect) begin
                        w_state_nxt = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Only one response can be in flight, so its arrival ends the drain.
                    if (imem_resp_valid) begin
                        w_state_nxt = S_REQ;
                    end
                end
                S_OUT: begin
                    inst_valid = 1'b1;
                    w_handoff  = inst_ready && !redirect;
                    if (w_handoff || redirect) begin
                        w_state_nxt = S_REQ;
                    end
                end
                default: begin
                    w_state_nxt = S_REQ;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inst       <= '0;
            r_inst_pc    <= '0;
            r_inst_fault <= 1'b0;
            r_fetch_cnt  <= '0;
        end else begin
            if (w_req_fire) begin
                r_inst_pc <= pc;
            end
            if (w_capture) begin
                r_inst       <= imem_resp_data;
                r_inst_fault <= imem_resp_err;
            end
            if (w_handoff) begin
                r_fetch_cnt <= r_fetch_cnt + 1'b1;
            end
        end
    end

    assign imem_req_addr = pc;
    assign pc_wen        = w_handoff;
    assign inst          = r_inst;
    assign inst_pc       = r_inst_pc;
    assign inst_fault    = r_inst_fault;
    assign fetch_cnt     = r_fetch_cnt;

    // A response is only legal while one is awaited.
    a_resp_when_awaited: assert property (@(posedge clk) disable iff (rst)
        !(imem_resp_valid && ((r_state == S_REQ) || (r_state == S_OUT))));

endmodule
`default_nettype wire
